// File: rtl/pool4_seq.sv
// pool4_seq: steps a 4:1 window mux through its four positions, samples each
// selected value, and reduces the 2x2 window to one value by max or average.
// The result is held on a valid/ready output until the next stage takes it.
module pool4_seq #(
    parameter int N = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic [1:0] sel,
    input  logic [N:0] mux_in,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:0] pool_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t       state;
    logic         mode_q;
    logic [N+2:0] acc;
    logic [N:0]   maxr;
    logic [N+2:0] acc_nxt;
    logic [N:0]   max_nxt;

    // Running reductions including the sample on the current cycle; the
    // first window position overwrites max so nothing stale leaks in.
    always_comb begin
        acc_nxt = acc + {2'b00, mux_in};
        max_nxt = maxr;
        if (sel == 2'd0 || mux_in > maxr)
            max_nxt = mux_in;
    end

    // Control FSM with registered sel/busy/out_valid and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            acc       <= '0;
            maxr      <= '0;
            sel       <= 2'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            pool_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        acc    <= '0;
                        maxr   <= '0;
                        sel    <= 2'd0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    acc  <= acc_nxt;
                    maxr <= max_nxt;
                    if (sel == 2'd3) begin
                        // Average is floor(sum/4); sum fits in N+3 bits so the
                        // top N+1 bits are the exact truncated mean.
                        pool_out  <= mode_q ? acc_nxt[N+2:2] : max_nxt;
                        out_valid <= 1'b1;
                        sel       <= 2'd0;
                        state     <= DONE;
                    end else begin
                        sel <= sel + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back: restart the scan without an IDLE bubble.
                            mode_q <= mode;
                            acc    <= '0;
                            maxr   <= '0;
                            sel    <= 2'd0;
                            state  <= SCAN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sel       <= 2'd0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pool4_seq.md
# pool4_seq

Sequential 2x2 pooling stage that sits directly downstream of the 4:1 window multiplexer in the CNN datapath. It drives the multiplexer select through the four window positions, samples the selected value each cycle, and reduces the four samples to one pooled value by max or average. The result is presented on a valid/ready output handshake for the next layer stage.

## Interface

Parameters:
- N, default 7: MSB index of the data path; data width is N+1 bits, unsigned.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request one pooling operation; honoured only in IDLE, or in DONE on the cycle the result is accepted.
- mode  input  1  0 = max pooling, 1 = average pooling; sampled on the cycle start is accepted.
- sel  output  2  window select to the 4:1 multiplexer.
- mux_in  input  N+1  selected window value returned by the multiplexer, combinational from sel.
- busy  output  1  high in SCAN and DONE.
- out_valid  output  1  pooled result valid.
- out_ready  input  1  downstream accepts result.
- pool_out  output  N+1  pooled result.

## Operation

- FSM states: IDLE, SCAN, DONE.
- IDLE: sel = 0, busy = 0, out_valid = 0. On start = 1: latch mode, clear accumulator and max register, go to SCAN with sel = 0.
- SCAN: four cycles, sel = 0, 1, 2, 3 in order. Each cycle samples mux_in for the current sel.
  - Max mode: running max register = max(running max, mux_in), unsigned compare; first sample loads unconditionally.
  - Average mode: accumulator (N+3 bits) += mux_in; no overflow possible.
  - After the sel = 3 sample: pool_out loads the result and the FSM goes to DONE; sel returns to 0.
- Average result: accumulator >> 2, truncation (floor), width N+1; max value in gives max value out.
- DONE: out_valid = 1, pool_out held stable until accepted. On out_valid && out_ready:
  - start = 1 in the same cycle: latch new mode, go directly to SCAN (back-to-back, no IDLE bubble).
  - otherwise: go to IDLE; out_valid drops next cycle.
- start in SCAN, or in DONE without out_ready, is ignored (not queued).
- mode changes after acceptance have no effect on the running operation.
- pool_out retains its last value in IDLE and during SCAN until the next result loads.

## Timing

- Reset (asynchronous, rst_n low): state = IDLE, sel = 0, busy = 0, out_valid = 0, pool_out = 0, accumulator and max register = 0. Reset during SCAN or DONE aborts the operation; no partial result is emitted.
- Cycle 0: start sampled high in IDLE. Cycles 1-4: SCAN, sel = 0,1,2,3, busy = 1. Cycle 5: DONE, out_valid = 1, pool_out valid.
- Latency start to out_valid: 5 cycles. Throughput with out_ready held high and start held high: one result per 5 cycles.
- mux_in must be stable from sel change to the next rising edge (one-cycle combinational path through the multiplexer).
- busy = 1 from the cycle after start acceptance through the handshake cycle of DONE.

## Test plan

- Reset then start, mode = 0, mux returns 1, 4, 9, 15 for sel 0..3 -> sel sequence 0,1,2,3 on cycles 1-4; out_valid on cycle 5; pool_out = 15.
- Same window, mode = 1 -> pool_out = 7 (29 >> 2); all inputs 255 with N = 7, mode = 1 -> pool_out = 255 (no overflow).
- Max ordering: inputs 200, 3, 150, 199, mode = 0 -> pool_out = 200 (first sample wins, later smaller values do not replace).
- Backpressure: out_ready low for 6 cycles after out_valid -> out_valid and pool_out held stable, start pulses ignored; out_ready high with start high -> next cycle SCAN with sel = 0, no IDLE cycle.
- start asserted during SCAN cycle 2 -> ignored, exactly one result produced.
- rst_n low during SCAN cycle 3 -> all outputs immediately at reset values; after release, a fresh start with 1,4,9,15, mode = 0 yields 15 with no residue from the aborted scan.
